// File: rtl/dual_issue_scheduler_pkg.sv
// Shared types and instruction field helpers for the dual-issue scheduler.
// Field layout (MSB first): opcode[4], imm flag[1], rd, rs1, rs2 (REG_W each), then unused low bits.
// Helpers take the instruction zero-extended to MAX_INSTR_W plus the actual widths.
package dual_issue_scheduler_pkg;

    localparam int MAX_INSTR_W = 32;
    localparam int MAX_REG_W   = 8;

    localparam logic [3:0] NOP_OPC = 4'h0;

    typedef logic [MAX_INSTR_W-1:0] instr_t;
    typedef logic [MAX_REG_W-1:0]   reg_idx_t;

    // One issued destination as remembered by the hazard window.
    typedef struct packed {
        logic     vld;
        reg_idx_t rd;
    } dest_t;

    function automatic logic [3:0] f_opc(input instr_t instr, input int iw);
        return 4'(instr >> (iw - 4));
    endfunction

    function automatic logic f_imm(input instr_t instr, input int iw);
        instr_t sh;
        sh = instr >> (iw - 5);
        return sh[0];
    endfunction

    function automatic reg_idx_t f_field(input instr_t instr, input int lsb, input int rw);
        instr_t mask;
        mask = (instr_t'(1) << rw) - instr_t'(1);
        return reg_idx_t'((instr >> lsb) & mask);
    endfunction

    function automatic reg_idx_t f_rd(input instr_t instr, input int iw, input int rw);
        return f_field(instr, iw - 5 - rw, rw);
    endfunction

    function automatic reg_idx_t f_rs1(input instr_t instr, input int iw, input int rw);
        return f_field(instr, iw - 5 - 2 * rw, rw);
    endfunction

    function automatic reg_idx_t f_rs2(input instr_t instr, input int iw, input int rw);
        return f_field(instr, iw - 5 - 3 * rw, rw);
    endfunction

    // rs1 is always a source; rs2 only for register-register forms.
    function automatic logic reads_reg(input instr_t instr, input reg_idx_t r,
                                       input int iw, input int rw);
        return (f_rs1(instr, iw, rw) == r) ||
               (!f_imm(instr, iw) && (f_rs2(instr, iw, rw) == r));
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Fetch-side push and issue-side result bundle for the dual-issue scheduler.
// master: fetch/downstream driver (pushes pairs, drives stall/flush); slave: the scheduler.
// in_ready is combinational from registered state; all issue outputs are registered.
interface dual_issue_scheduler_if #(parameter int INSTR_W = 16);

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr0;
    logic [INSTR_W-1:0] in_instr1;
    logic               out_stall;
    logic               flush;
    logic               out_valid0;
    logic               out_valid1;
    logic [INSTR_W-1:0] out_instr0;
    logic [INSTR_W-1:0] out_instr1;
    logic               hazard_stall;

    modport master (
        output in_valid, in_instr0, in_instr1, out_stall, flush,
        input  in_ready, out_valid0, out_valid1, out_instr0, out_instr1, hazard_stall
    );

    modport slave (
        input  in_valid, in_instr0, in_instr1, out_stall, flush,
        output in_ready, out_valid0, out_valid1, out_instr0, out_instr1, hazard_stall
    );

endinterface

// File: rtl/dual_issue_scheduler_dest_window.sv
// Shift register of recently issued destinations (2 lanes x WINDOW stages) with two source-hit queries.
// Latency: hits are combinational on the registered stages; a new entry is visible the cycle after advance.
// Backpressure: stages hold whenever advance is low (downstream stall or flush).
module dual_issue_scheduler_dest_window
    import dual_issue_scheduler_pkg::*;
#(
    parameter int WINDOW  = 3,
    parameter int INSTR_W = 16,
    parameter int REG_W   = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   advance,
    input  dest_t  issue0,
    input  dest_t  issue1,
    input  instr_t query0,
    input  instr_t query1,
    output logic   hit0,
    output logic   hit1
);

    dest_t stage_q [WINDOW][2];
    dest_t stage_d [WINDOW][2];

    always_comb begin
        stage_d = stage_q;
        if (advance) begin
            stage_d[0][0] = issue0;
            stage_d[0][1] = issue1;
            for (int s = 1; s < WINDOW; s++) begin
                stage_d[s][0] = stage_q[s-1][0];
                stage_d[s][1] = stage_q[s-1][1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < WINDOW; s++) begin
                stage_q[s][0] <= '0;
                stage_q[s][1] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    always_comb begin
        hit0 = 1'b0;
        hit1 = 1'b0;
        for (int s = 0; s < WINDOW; s++) begin
            for (int l = 0; l < 2; l++) begin
                if (stage_q[s][l].vld && reads_reg(query0, stage_q[s][l].rd, INSTR_W, REG_W))
                    hit0 = 1'b1;
                if (stage_q[s][l].vld && reads_reg(query1, stage_q[s][l].rd, INSTR_W, REG_W))
                    hit1 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: queues fetched pairs (NOPs dropped) and issues 0/1/2 per cycle past RAW checks.
// Latency: entry pushed at edge N can issue at edge N+1; outputs, hazard_stall and count are registered.
// Backpressure: in_ready while >=2 slots free; out_stall freezes issue/window but still accepts pushes; flush wins.
// Ports: clk, rst (async, active-high); bus (slave modport) carries push pair, stall/flush and both issue lanes.
module dual_issue_scheduler
    import dual_issue_scheduler_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int REG_W   = 3,
    parameter int WINDOW  = 3,
    parameter int QDEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dual_issue_scheduler_if.slave bus
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [INSTR_W-1:0] word_t;

    word_t            mem_q [QDEPTH];
    word_t            mem_d [QDEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid0_q, out_valid0_d;
    logic             out_valid1_q, out_valid1_d;
    word_t            out_instr0_q, out_instr0_d;
    word_t            out_instr1_q, out_instr1_d;
    logic             hazard_stall_q, hazard_stall_d;

    logic [PTR_W-1:0] rd_ptr_nx;
    logic [PTR_W-1:0] wr_ptr_1;
    word_t            h0, h1;
    logic             h0_ex, h1_ex;
    reg_idx_t         h0_rd, h1_rd;
    logic             hit0, hit1;
    logic             ok0, ok1;
    logic             advance;
    logic             accept, push0, push1;
    logic [1:0]       n_push, n_pop;
    dest_t            issue0, issue1;

    assign bus.in_ready = (count_q <= CNT_W'(QDEPTH - 2));

    // Head pair and occupancy.
    assign rd_ptr_nx = rd_ptr_q + PTR_W'(1);
    assign h0        = mem_q[rd_ptr_q];
    assign h1        = mem_q[rd_ptr_nx];
    assign h0_ex     = (count_q != '0);
    assign h1_ex     = (count_q >= CNT_W'(2));
    assign h0_rd     = f_rd(instr_t'(h0), INSTR_W, REG_W);
    assign h1_rd     = f_rd(instr_t'(h1), INSTR_W, REG_W);

    // Lane 1 additionally must not read or overwrite lane 0's destination.
    assign ok0 = h0_ex && !hit0;
    assign ok1 = ok0 && h1_ex && !hit1 &&
                 !reads_reg(instr_t'(h1), h0_rd, INSTR_W, REG_W) &&
                 (h1_rd != h0_rd);

    assign advance = !bus.out_stall && !bus.flush;

    assign accept = bus.in_valid && bus.in_ready && !bus.flush;
    assign push0  = accept && (f_opc(instr_t'(bus.in_instr0), INSTR_W) != NOP_OPC);
    assign push1  = accept && (f_opc(instr_t'(bus.in_instr1), INSTR_W) != NOP_OPC);
    assign n_push = 2'(push0) + 2'(push1);
    assign n_pop  = advance ? (2'(ok0) + 2'(ok1)) : 2'd0;

    // A lone younger instruction lands in the first free slot.
    assign wr_ptr_1 = wr_ptr_q + PTR_W'(push0);

    assign issue0 = '{vld: ok0, rd: h0_rd};
    assign issue1 = '{vld: ok1, rd: h1_rd};

    dual_issue_scheduler_dest_window #(
        .WINDOW  (WINDOW),
        .INSTR_W (INSTR_W),
        .REG_W   (REG_W)
    ) u_dest_window (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .issue0  (issue0),
        .issue1  (issue1),
        .query0  (instr_t'(h0)),
        .query1  (instr_t'(h1)),
        .hit0    (hit0),
        .hit1    (hit1)
    );

    always_comb begin
        mem_d = mem_q;
        if (push0) mem_d[wr_ptr_q] = bus.in_instr0;
        if (push1) mem_d[wr_ptr_1] = bus.in_instr1;

        rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
        count_d  = count_q + CNT_W'(n_push) - CNT_W'(n_pop);

        out_valid0_d   = out_valid0_q;
        out_valid1_d   = out_valid1_q;
        out_instr0_d   = out_instr0_q;
        out_instr1_d   = out_instr1_q;
        hazard_stall_d = h0_ex && !ok0 && advance;

        if (bus.flush) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            out_valid0_d = 1'b0;
            out_valid1_d = 1'b0;
            out_instr0_d = '0;
            out_instr1_d = '0;
        end else if (advance) begin
            out_valid0_d = ok0;
            out_valid1_d = ok1;
            out_instr0_d = ok0 ? h0 : '0;
            out_instr1_d = ok1 ? h1 : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            out_valid0_q   <= 1'b0;
            out_valid1_q   <= 1'b0;
            out_instr0_q   <= '0;
            out_instr1_q   <= '0;
            hazard_stall_q <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            out_valid0_q   <= out_valid0_d;
            out_valid1_q   <= out_valid1_d;
            out_instr0_q   <= out_instr0_d;
            out_instr1_q   <= out_instr1_d;
            hazard_stall_q <= hazard_stall_d;
        end
    end

    assign bus.out_valid0   = out_valid0_q;
    assign bus.out_valid1   = out_valid1_q;
    assign bus.out_instr0   = out_instr0_q;
    assign bus.out_instr1   = out_instr1_q;
    assign bus.hazard_stall = hazard_stall_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: directed scenarios with literal expectations, then randomized traffic.
// A queue/bitmask reference model predicts in_ready, count and every registered output each cycle.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
`timescale 1ns/1ps
module tb_dual_issue_scheduler;

    localparam int INSTR_W = 16;
    localparam int REG_W   = 3;
    localparam int WINDOW  = 3;
    localparam int QDEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dual_issue_scheduler_if #(.INSTR_W(INSTR_W)) bus ();

    dual_issue_scheduler #(
        .INSTR_W (INSTR_W),
        .REG_W   (REG_W),
        .WINDOW  (WINDOW),
        .QDEPTH  (QDEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [15:0] mq [$];   // queued instructions, oldest first
    logic [7:0]  win [$];  // per issue cycle: bitmask of destinations written, newest first
    logic        exp_v0, exp_v1, exp_hz;
    logic [15:0] exp_i0, exp_i1;

    function automatic logic [15:0] mk(input int opc, input int imm, input int rd,
                                       input int rs1, input int rs2);
        logic [15:0] w;
        w = {opc[3:0], imm[0], rd[2:0], rs1[2:0], rs2[2:0], 2'b00};
        return w;
    endfunction

    function automatic logic [7:0] srcs(input logic [15:0] x);
        logic [7:0] m;
        m = 8'b1 << x[7:5];
        if (!x[11]) m = m | (8'b1 << x[4:2]);
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        win.delete();
        repeat (WINDOW) win.push_back(8'h00);
        exp_v0 = 1'b0; exp_v1 = 1'b0; exp_hz = 1'b0;
        exp_i0 = '0;   exp_i1 = '0;
    endtask

    // One clock: predict from pre-edge state and inputs, step the edge, compare.
    task automatic tick();
        logic [7:0]  busy, m;
        logic        ok0, ok1, ready;
        logic [15:0] h0, h1;
        ready = (mq.size() <= QDEPTH - 2);
        chk("in_ready", int'(bus.in_ready), int'(ready));
        busy = '0;
        foreach (win[k]) busy = busy | win[k];
        h0 = '0; h1 = '0; ok0 = 1'b0; ok1 = 1'b0;
        if (mq.size() >= 1) begin
            h0  = mq[0];
            ok0 = ((srcs(h0) & busy) == 0);
        end
        if (ok0 && mq.size() >= 2) begin
            h1  = mq[1];
            ok1 = ((srcs(h1) & busy) == 0) && ((srcs(h1) & (8'b1 << h0[10:8])) == 0) &&
                  (h1[10:8] != h0[10:8]);
        end
        if (bus.flush) begin
            mq.delete();
            exp_v0 = 1'b0; exp_v1 = 1'b0; exp_hz = 1'b0;
            exp_i0 = '0;   exp_i1 = '0;
        end else begin
            if (!bus.out_stall) begin
                exp_hz = (mq.size() != 0) && !ok0;
                exp_v0 = ok0; exp_i0 = ok0 ? h0 : 16'h0;
                exp_v1 = ok1; exp_i1 = ok1 ? h1 : 16'h0;
                m = '0;
                if (ok0) m = m | (8'b1 << h0[10:8]);
                if (ok1) m = m | (8'b1 << h1[10:8]);
                win.push_front(m);
                void'(win.pop_back());
                if (ok0) void'(mq.pop_front());
                if (ok1) void'(mq.pop_front());
            end else begin
                exp_hz = 1'b0;
            end
            if (bus.in_valid && ready) begin
                if (bus.in_instr0[15:12] != 4'h0) mq.push_back(bus.in_instr0);
                if (bus.in_instr1[15:12] != 4'h0) mq.push_back(bus.in_instr1);
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid0", int'(bus.out_valid0), int'(exp_v0));
        chk("out_valid1", int'(bus.out_valid1), int'(exp_v1));
        chk("out_instr0", int'(bus.out_instr0), int'(exp_i0));
        chk("out_instr1", int'(bus.out_instr1), int'(exp_i1));
        chk("hazard_stall", int'(bus.hazard_stall), int'(exp_hz));
        chk("count", int'(dut.count_q), mq.size());
    endtask

    task automatic drive(input logic v, input logic [15:0] i0, input logic [15:0] i1,
                         input logic st, input logic fl);
        bus.in_valid  = v;
        bus.in_instr0 = i0;
        bus.in_instr1 = i1;
        bus.out_stall = st;
        bus.flush     = fl;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    logic [15:0] a0, a1, b0, b1, c0, c1, d1, p, ai, bd, cd, dd, g, r0, r1;

    initial begin
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid0", int'(bus.out_valid0), 0);
        chk("rst_out_valid1", int'(bus.out_valid1), 0);
        chk("rst_out_instr0", int'(bus.out_instr0), 0);
        chk("rst_out_instr1", int'(bus.out_instr1), 0);
        chk("rst_hazard", int'(bus.hazard_stall), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        rst = 1'b0;

        // Independent pair issues together one edge after the push.
        a0 = mk(1, 0, 1, 2, 3); a1 = mk(1, 0, 4, 5, 6);
        drive(1'b1, a0, a1, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); tick();
        chk("A_v0", int'(bus.out_valid0), 1);
        chk("A_v1", int'(bus.out_valid1), 1);
        chk("A_i0", int'(bus.out_instr0), int'(a0));
        chk("A_i1", int'(bus.out_instr1), int'(a1));
        chk("A_hz", int'(bus.hazard_stall), 0);
        idle(3);

        // Intra-pair RAW: lane 0 alone, then the consumer waits WINDOW cycles.
        b0 = mk(1, 0, 1, 2, 3); b1 = mk(1, 0, 4, 1, 5);
        drive(1'b1, b0, b1, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); tick();
        chk("B_first_v0", int'(bus.out_valid0), 1);
        chk("B_first_v1", int'(bus.out_valid1), 0);
        for (int k = 0; k < WINDOW; k++) begin
            tick();
            chk("B_wait_v0", int'(bus.out_valid0), 0);
            chk("B_wait_hz", int'(bus.hazard_stall), 1);
        end
        tick();
        chk("B_late_v0", int'(bus.out_valid0), 1);
        chk("B_late_i0", int'(bus.out_instr0), int'(b1));
        idle(3);

        // WAW pair: same rd, issued in consecutive cycles on lane 0.
        c0 = mk(2, 0, 2, 1, 3); c1 = mk(3, 0, 2, 5, 6);
        drive(1'b1, c0, c1, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); tick();
        chk("C_first_v1", int'(bus.out_valid1), 0);
        chk("C_first_i0", int'(bus.out_instr0), int'(c0));
        tick();
        chk("C_second_v0", int'(bus.out_valid0), 1);
        chk("C_second_i0", int'(bus.out_instr0), int'(c1));
        idle(3);

        // NOP in the older slot is dropped.
        d1 = mk(1, 0, 7, 1, 2);
        drive(1'b1, 16'h0, d1, 1'b0, 1'b0); tick();
        chk("D_count", int'(dut.count_q), 1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); tick();
        chk("D_v0", int'(bus.out_valid0), 1);
        chk("D_i0", int'(bus.out_instr0), int'(d1));
        idle(3);

        // Fill while a window hazard on r3 persists, then flush under stall.
        p  = mk(1, 1, 3, 0, 0);
        ai = mk(1, 0, 5, 6, 7); bd = mk(1, 0, 6, 3, 0);
        cd = mk(1, 1, 1, 3, 0); dd = mk(1, 0, 2, 3, 3);
        g  = mk(1, 0, 4, 3, 1);
        drive(1'b1, p, 16'h0, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); tick();
        drive(1'b1, ai, bd, 1'b1, 1'b0); tick();
        drive(1'b1, cd, dd, 1'b1, 1'b0); tick();
        chk("E_count4", int'(dut.count_q), 4);
        chk("E_ready4", int'(bus.in_ready), 0);
        drive(1'b1, mk(5, 0, 1, 1, 1), mk(6, 0, 2, 2, 2), 1'b1, 1'b0); tick();
        chk("E_drop4", int'(dut.count_q), 4);
        drive(1'b1, mk(5, 0, 1, 1, 1), mk(6, 0, 2, 2, 2), 1'b0, 1'b0); tick();
        chk("E_pop_i0", int'(bus.out_instr0), int'(ai));
        chk("E_pop_v1", int'(bus.out_valid1), 0);
        chk("E_count3", int'(dut.count_q), 3);
        chk("E_ready3", int'(bus.in_ready), 0);
        drive(1'b1, mk(5, 0, 1, 1, 1), mk(6, 0, 2, 2, 2), 1'b1, 1'b0); tick();
        chk("E_drop3", int'(dut.count_q), 3);
        drive(1'b1, mk(5, 0, 1, 1, 1), mk(6, 0, 2, 2, 2), 1'b1, 1'b1); tick();
        chk("F_count", int'(dut.count_q), 0);
        chk("F_v0", int'(bus.out_valid0), 0);
        chk("F_v1", int'(bus.out_valid1), 0);
        chk("F_i0", int'(bus.out_instr0), 0);
        chk("F_i1", int'(bus.out_instr1), 0);
        drive(1'b1, g, 16'h0, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); tick();
        chk("F_window_v0", int'(bus.out_valid0), 0);
        chk("F_window_hz", int'(bus.hazard_stall), 1);
        idle(4);

        // Flush discards a push that would otherwise be accepted.
        drive(1'b1, mk(1, 0, 1, 2, 3), mk(1, 0, 4, 5, 6), 1'b0, 1'b1); tick();
        chk("F_push_dropped", int'(dut.count_q), 0);

        // Randomized traffic, with one asynchronous reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                rst = 1'b1;
                #1;
                chk("arst_v0", int'(bus.out_valid0), 0);
                chk("arst_i0", int'(bus.out_instr0), 0);
                chk("arst_count", int'(dut.count_q), 0);
                model_reset();
                @(negedge clk);
                rst = 1'b0;
            end
            r0 = ($urandom_range(0, 6) == 0) ? 16'h0 :
                 mk($urandom_range(1, 15), $urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7));
            r1 = ($urandom_range(0, 6) == 0) ? 16'h0 :
                 mk($urandom_range(1, 15), $urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7));
            drive($urandom_range(0, 9) < 7, r0, r1,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 31) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
